// File: rtl/cache_bus_burst_ctrl.sv
// Cache-line to AHB-Lite incrementing burst bridge.
// Fetches assemble into fetch_buffer; writebacks stream cache words out by beat.
module cache_bus_burst_ctrl #(
  parameter int unsigned PA_BITS   = 32,
  parameter int unsigned AHBW      = 32,
  parameter int unsigned LINELEN   = 256,
  localparam int unsigned BEATS     = LINELEN / AHBW,
  localparam int unsigned LOGBWPL   = $clog2(BEATS),
  localparam int unsigned OFFSETLEN = $clog2(LINELEN / 8)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [AHBW-1:0]    ReadDataWord,
  output logic               CacheBusAck,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic               SelBusBeat,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               BusCommitted,
  output logic [PA_BITS-1:0] HADDR,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [2:0]         HSIZE,
  output logic [2:0]         HBURST,
  output logic [AHBW-1:0]    HWDATA,
  input  logic [AHBW-1:0]    HRDATA,
  input  logic               HREADY
);

  localparam int unsigned LINE_BITS = PA_BITS - OFFSETLEN;
  localparam int unsigned BYTE_BITS = OFFSETLEN - LOGBWPL;
  localparam logic [LOGBWPL-1:0] LAST_BEAT = LOGBWPL'(BEATS - 1);
  localparam logic [2:0] HSIZE_VAL  = 3'($clog2(AHBW / 8));
  localparam logic [2:0] HBURST_VAL = (BEATS == 4)  ? 3'b011 :
                                      (BEATS == 8)  ? 3'b101 :
                                      (BEATS == 16) ? 3'b111 : 3'b001;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t                 state;
  logic                   is_write;
  logic [LINE_BITS-1:0]   line_adr;
  logic [LOGBWPL-1:0]     adr_beat;
  logic                   adr_done;
  logic [LOGBWPL-1:0]     data_beat;
  logic                   data_active;
  logic                   in_burst;
  logic                   adr_accept;
  logic                   data_fire;

  // Byte offset within the line is implied by the beat index.
  logic unused_adr_bits;
  assign unused_adr_bits = &{1'b0, CacheBusAdr[OFFSETLEN-1:0]};

  assign in_burst     = (state == S_BURST);
  assign adr_accept   = in_burst && !adr_done && HREADY;
  assign data_fire    = data_active && HREADY;
  assign CacheBusAck  = data_fire && (data_beat == LAST_BEAT);

  assign BusCommitted = in_burst;
  assign SelBusBeat   = in_burst;
  assign BeatCount    = adr_beat;
  assign HADDR        = {line_adr, adr_beat, {BYTE_BITS{1'b0}}};
  assign HWRITE       = in_burst && is_write;
  assign HSIZE        = HSIZE_VAL;
  assign HBURST       = HBURST_VAL;

  always_comb begin
    HTRANS = TRANS_IDLE;
    if (in_burst && !adr_done)
      HTRANS = (adr_beat == '0) ? TRANS_NONSEQ : TRANS_SEQ;
  end

  // Request latch, address/data beat pipeline and line assembly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      is_write    <= 1'b0;
      line_adr    <= '0;
      adr_beat    <= '0;
      adr_done    <= 1'b0;
      data_beat   <= '0;
      data_active <= 1'b0;
      HWDATA      <= '0;
      FetchBuffer <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CacheBusRW != 2'b00) begin
            state       <= S_BURST;
            is_write    <= CacheBusRW[0];
            line_adr    <= CacheBusAdr[PA_BITS-1:OFFSETLEN];
            adr_beat    <= '0;
            adr_done    <= 1'b0;
            data_active <= 1'b0;
          end
        end
        S_BURST: begin
          if (adr_accept) begin
            adr_beat    <= adr_beat + LOGBWPL'(1);
            adr_done    <= (adr_beat == LAST_BEAT);
            data_active <= 1'b1;
            data_beat   <= adr_beat;
            if (is_write)
              HWDATA <= ReadDataWord;
          end else if (data_fire) begin
            data_active <= 1'b0;
          end
          if (data_fire && !is_write)
            FetchBuffer[32'(data_beat) * AHBW +: AHBW] <= HRDATA;
          if (CacheBusAck) begin
            state       <= S_IDLE;
            data_active <= 1'b0;
            adr_done    <= 1'b0;
            adr_beat    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_burst_ctrl.sv
// Directed bench for cache_bus_burst_ctrl: fetch, writeback, stalls, reset abort.
module tb_cache_bus_burst_ctrl;

  localparam int unsigned BEATS = 8;

  logic         clk;
  logic         reset;
  logic [1:0]   cache_bus_rw;
  logic [31:0]  cache_bus_adr;
  logic [31:0]  read_data_word;
  logic         ack;
  logic [2:0]   beat_count;
  logic         sel_bus_beat;
  logic [255:0] fetch_buffer;
  logic         bus_committed;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic [2:0]   hburst;
  logic [31:0]  hwdata;
  logic [31:0]  hrdata;
  logic         hready;

  int n_vec = 0;
  int n_err = 0;
  logic [255:0] fb_exp;

  cache_bus_burst_ctrl #(.PA_BITS(32), .AHBW(32), .LINELEN(256)) dut (
    .clk(clk), .reset(reset), .CacheBusRW(cache_bus_rw), .CacheBusAdr(cache_bus_adr),
    .ReadDataWord(read_data_word), .CacheBusAck(ack), .BeatCount(beat_count),
    .SelBusBeat(sel_bus_beat), .FetchBuffer(fetch_buffer), .BusCommitted(bus_committed),
    .HADDR(haddr), .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
    .HWDATA(hwdata), .HRDATA(hrdata), .HREADY(hready)
  );

  // Cache word mux as the cache would drive it.
  assign read_data_word = 32'h1000_0000 + 32'(beat_count);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One burst from request (cycle 0) to the idle cycle after ack.
  task automatic run_burst(input logic [1:0] rw, input logic [31:0] adr, input logic [31:0] rbase,
                           input int stall_at, input int exp_ack_cycle);
    int a = 0;
    int d = -1;
    int ack_cyc = -1;
    logic wr;
    wr = rw[0];
    cache_bus_rw  = rw;
    cache_bus_adr = adr;
    hready = 1'b1;
    check("req_htrans_idle", 256'(htrans), 256'(2'b00));
    check("req_not_committed", 256'(bus_committed), 256'(0));
    tick();
    cache_bus_rw  = 2'b00;
    cache_bus_adr = 32'hDEAD_BEE0;
    for (int c = 1; c < 40 && ack_cyc < 0; c++) begin
      hready = !(stall_at > 0 && c >= stall_at && c < stall_at + 3);
      hrdata = (d >= 0 && hready) ? rbase + 32'(d) : 32'hBAD0_0000;
      check("committed", 256'(bus_committed), 256'(1));
      check("sel_bus_beat", 256'(sel_bus_beat), 256'(1));
      if (a < BEATS) begin
        check("haddr", 256'(haddr), 256'(adr + 32'(4 * a)));
        check("htrans", 256'(htrans), 256'((a == 0) ? 2'b10 : 2'b11));
        check("beat_count", 256'(beat_count), 256'(a));
        check("hwrite", 256'(hwrite), 256'(wr));
      end else begin
        check("htrans_done", 256'(htrans), 256'(2'b00));
      end
      if (wr && d >= 0)
        check("hwdata", 256'(hwdata), 256'(32'h1000_0000 + 32'(d)));
      check("ack", 256'(ack), 256'(hready && d == BEATS - 1));
      if (ack) ack_cyc = c;
      if (hready) begin
        d = (a < BEATS) ? a : -1;
        if (a < BEATS) a++;
      end
      tick();
    end
    check("ack_cycle", 256'(ack_cyc), 256'(exp_ack_cycle));
    check("post_idle_htrans", 256'(htrans), 256'(2'b00));
    check("post_not_committed", 256'(bus_committed), 256'(0));
    check("post_no_ack", 256'(ack), 256'(0));
    if (!wr)
      for (int k = 0; k < BEATS; k++) fb_exp[k*32 +: 32] = rbase + 32'(k);
    check("fetch_buffer", fetch_buffer, fb_exp);
  endtask

  initial begin
    reset = 1'b0;
    cache_bus_rw = 2'b00;
    cache_bus_adr = '0;
    hrdata = '0;
    hready = 1'b1;
    fb_exp = '0;
    repeat (3) tick();
    check("rst_htrans", 256'(htrans), 256'(2'b00));
    check("rst_hwrite", 256'(hwrite), 256'(0));
    check("rst_hwdata", 256'(hwdata), 256'(0));
    check("rst_fetch_buffer", fetch_buffer, 256'(0));
    check("rst_committed", 256'(bus_committed), 256'(0));
    check("rst_ack", 256'(ack), 256'(0));
    check("hsize", 256'(hsize), 256'(3'b010));
    check("hburst", 256'(hburst), 256'(3'b101));
    reset = 1'b1;
    tick();

    // Plain fetch, then a stalled writeback chained straight into a fetch.
    run_burst(2'b10, 32'h8000_0040, 32'h0000_00A0, 0, 9);
    run_burst(2'b01, 32'h0000_1000, 32'h0, 4, 12);
    run_burst(2'b10, 32'h2000_0080, 32'h0000_00B0, 0, 9);

    // Reset at data beat 5 of a fetch abandons the burst.
    cache_bus_rw = 2'b10;
    cache_bus_adr = 32'h8000_0040;
    tick();
    cache_bus_rw = 2'b00;
    for (int c = 1; c < 7; c++) begin
      hrdata = 32'hD0 + 32'(c - 2);
      tick();
    end
    hrdata = 32'hD5;
    check("abort_beat5_no_ack", 256'(ack), 256'(0));
    reset = 1'b0;
    tick();
    check("abort_htrans", 256'(htrans), 256'(2'b00));
    check("abort_committed", 256'(bus_committed), 256'(0));
    check("abort_fetch_buffer", fetch_buffer, 256'(0));
    check("abort_ack", 256'(ack), 256'(0));
    check("abort_hwdata", 256'(hwdata), 256'(0));
    fb_exp = '0;
    reset = 1'b1;
    tick();

    // Both request bits set behaves as a writeback; then a stalled fetch.
    run_burst(2'b11, 32'h4000_0020, 32'h0, 0, 9);
    run_burst(2'b10, 32'h0000_0100, 32'h0000_00C0, 4, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_bus_burst_ctrl.md
Name: cache_bus_burst_ctrl

Overview:
- Bus-side neighbour of the I$/D$. Turns the cache's line-level request (CacheBusRW, CacheBusAdr) into one AHB-Lite incrementing burst of BEATS beats.
- On a fetch, assembles the incoming beats into FetchBuffer. On a writeback, streams cache words out using BeatCount.
- Returns a single-cycle CacheBusAck when the last data beat completes.
- Sits between the cache and the AHB arbiter.

Parameters:
- PA_BITS, 32, physical address width.
- AHBW, 32, bus data width in bits (32 or 64).
- LINELEN, 256, cache line width in bits. Must be a multiple of AHBW with LINELEN/AHBW ≥ 2.
- Derived localparams: BEATS = LINELEN/AHBW; LOGBWPL = $clog2(BEATS); OFFSETLEN = $clog2(LINELEN/8).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- CacheBusRW  in  2  [1]=line fetch (read), [0]=line writeback (write).
- CacheBusAdr  in  PA_BITS  line-aligned bus address.
- ReadDataWord  in  AHBW  cache word selected by BeatCount (writeback data).
- CacheBusAck  out  1  last beat done; one cycle.
- BeatCount  out  LOGBWPL  beat index currently in address phase.
- SelBusBeat  out  1  cache must index its word mux with BeatCount.
- FetchBuffer  out  LINELEN  assembled fetched line.
- BusCommitted  out  1  burst in flight; must not be interrupted.
- HADDR  out  PA_BITS  AHB address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- HWRITE  out  1  AHB write.
- HSIZE  out  3  $clog2(AHBW/8).
- HBURST  out  3  BEATS 4→011, 8→101, 16→111, otherwise 001 (INCR).
- HWDATA  out  AHBW  registered write data.
- HRDATA  in  AHBW  read data.
- HREADY  in  1  transfer completes / bus advances.

Behaviour:
- States: IDLE, BURST. Registered request latch: IsWrite, LineAdr.
- Counters: AdrBeat and DataBeat (LOGBWPL bits each), plus a DataActive flag.
- Reset (reset==0 at a clk edge):
  - state=IDLE; all counters and flags 0.
  - HTRANS=IDLE, HWRITE=0, HWDATA=0, FetchBuffer=0.
  - CacheBusAck=0, BusCommitted=0, SelBusBeat=0.
  - Reset mid-burst abandons the burst; the next cycle is IDLE.
- IDLE → BURST when CacheBusRW≠00:
  - Latch IsWrite=CacheBusRW[0] (write wins if both bits set) and LineAdr=CacheBusAdr[PA_BITS-1:OFFSETLEN].
  - AdrBeat=0.
- Address phase (in BURST):
  - HADDR = {LineAdr, AdrBeat, OFFSETLEN-LOGBWPL zeros}.
  - HTRANS = NONSEQ at AdrBeat 0, SEQ thereafter, IDLE once all BEATS addresses are accepted.
  - HWRITE = IsWrite. HSIZE and HBURST are constant during the burst.
  - An address beat is accepted when HTRANS≠IDLE & HREADY. Acceptance increments AdrBeat and sets DataActive with DataBeat=AdrBeat.
  - After the final address beat is accepted, address phase is done; no wrap.
- Writes: on write address acceptance, HWDATA ← ReadDataWord. The word is selected combinationally by the cache using BeatCount = AdrBeat.
- Reads: on a data beat with DataActive & HREADY, FetchBuffer[DataBeat*AHBW +: AHBW] ← HRDATA. Other slices are held.
- HREADY=0 freezes all address, data and HWDATA state. AHB pipelining means one address beat and one data beat complete together on each HREADY.
- CacheBusAck is combinational: DataActive & HREADY & DataBeat==BEATS-1. It is high exactly one cycle per burst.
- Next state after the ack cycle is IDLE.
  - A new request visible in that IDLE cycle (e.g. fetch after writeback) starts the next burst, giving a 1-cycle gap.
  - Back-to-back requests are legal.
- CacheBusRW and CacheBusAdr changes during BURST are ignored.
- BusCommitted = SelBusBeat = (state==BURST).
- Latency with HREADY always 1: request seen at cycle 0 → NONSEQ at cycle 1 → ack at cycle BEATS+1.

Test Plan:
- Fetch, BEATS=8, AHBW=32, CacheBusAdr=0x8000_0040, HRDATA=0xA0+beat, HREADY=1 → HADDR 0x40..0x5C step 4; HTRANS NONSEQ then 7×SEQ; ack at cycle 9; FetchBuffer word k = 0xA0+k.
- Writeback, ReadDataWord=0x1000_0000+BeatCount → HWRITE=1; HWDATA in data beat k = 0x1000_000k; exactly one ack; FetchBuffer unchanged.
- HREADY held low for 3 cycles at beat 3 → HADDR, HTRANS and HWDATA stable; ack delayed 3 cycles; no skipped or duplicated beats.
- Writeback ack followed immediately by CacheBusRW=10 → one IDLE cycle, then NONSEQ read to the new address; HWRITE=0.
- reset=0 at data beat 5 of a fetch → next cycle HTRANS=IDLE, BusCommitted=0, FetchBuffer=0, no ack; a new request restarts at beat 0.
- CacheBusRW=11 → treated as write burst; CacheBusAdr changed mid-burst → HADDR keeps the latched line.
